// File: rtl/vc_link_pkg.sv
// Shared credit-link definitions. The sender and the receiving converter both
// import this so they agree on buffer depth and credit counter width.
package vc_link_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CREDIT_NUM = 2;

  function automatic int credit_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating credit counter with a sticky overflow flag, shared by credit senders.
// The caller guarantees dec is only asserted while nonzero is high.
module credit_counter #(
  parameter int MAX = 2,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         nonzero,
  output logic         overflow_err
);

  logic full;

  assign full    = (cnt == W'(MAX));
  assign nonzero = (cnt != '0);

  // An excess credit is dropped rather than wrapping; the flag records it until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      overflow_err <= 1'b0;
    end else if (inc && !dec) begin
      if (full) overflow_err <= 1'b1;
      else      cnt          <= cnt + W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/vr_vc_converter.sv
// Valid/ready to valid/credit sender: forwards each accepted beat as a registered
// one-cycle pulse, spending one credit per beat.
module vr_vc_converter
  import vc_link_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int CREDIT_NUM = DEFAULT_CREDIT_NUM,
  localparam int CNT_W      = credit_cnt_width(CREDIT_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_credit_i,
  output logic [CNT_W-1:0]      credit_cnt_o,
  output logic                  credit_err_o
);

  logic send;
  logic have_credit;

  // Ready comes from the registered count only, so a returning credit takes
  // effect one cycle later and there is no m_credit_i -> s_ready_o path.
  assign s_ready_o = rst_n && have_credit;
  assign send      = s_valid_i && s_ready_o;

  credit_counter #(
    .MAX (CREDIT_NUM),
    .W   (CNT_W)
  ) u_credit_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc          (m_credit_i),
    .dec          (send),
    .cnt          (credit_cnt_o),
    .nonzero      (have_credit),
    .overflow_err (credit_err_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
    end else begin
      m_valid_o <= send;
      if (send) m_data_o <= s_data_i;
    end
  end

endmodule

// File: doc/vr_vc_converter.md
# vr_vc_converter

Valid/ready to valid/credit converter: the sending half of a credit-based link. It accepts a valid/ready stream from local logic and forwards each beat as a single-cycle valid pulse. Each beat consumes one credit. Credits are returned as single-cycle pulses by the receiving valid/credit-to-valid/ready converter. The block sits directly upstream of that receiver, and its buffer depth sets CREDIT_NUM.

## Interface
- DATA_WIDTH, 8, payload width in bits
- CREDIT_NUM, 2, credits owned by the link; must equal the receiver buffer depth; ≥1
- CNT_W, $clog2(CREDIT_NUM+1), credit counter width (derived, not overridden)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_data_i  in  DATA_WIDTH  upstream payload
- s_valid_i  in  1  upstream valid
- s_ready_o  out  1  upstream ready
- m_data_o  out  DATA_WIDTH  link payload, registered
- m_valid_o  out  1  link valid, one-cycle pulse per beat, registered
- m_credit_i  in  1  credit return, one credit per high cycle
- credit_cnt_o  out  CNT_W  current credit count (debug/status)
- credit_err_o  out  1  sticky credit-overflow flag

## Operation
- Credit counter cnt is reset to 0.
- The receiver returns CREDIT_NUM pulses after reset, so the block never preloads credits.
- s_ready_o = rst_n && (cnt != 0). It is decoded from registered cnt only. A credit arriving this cycle does not raise ready until the next cycle, so there is no combinational path from m_credit_i to s_ready_o.
- send = s_valid_i && s_ready_o.
- cnt_next = cnt + m_credit_i − send.
  - Simultaneous credit and send leaves cnt unchanged.
  - Underflow is impossible by construction.
- Overflow: m_credit_i && !send && cnt == CREDIT_NUM.
  - cnt saturates at CREDIT_NUM.
  - credit_err_o is set and stays set until reset.
  - Data path is unaffected.
- m_valid_o <= send.
- m_data_o <= s_data_i when send, else holds its value. It is not cleared after a beat.
- Beats are forwarded in acceptance order; no reordering, duplication or drop.
- Upstream may drop s_valid_i or change s_data_i while s_ready_o = 0; nothing is captured.

## Timing
- Reset values (rst_n = 0 at a clock edge):
  - m_valid_o = 0, m_data_o = 0
  - cnt = 0, credit_cnt_o = 0, credit_err_o = 0
  - s_ready_o = 0 combinationally while rst_n = 0
- Latency: beat accepted at edge t appears on m_valid_o/m_data_o during cycle t+1.
- Credit return at edge t raises s_ready_o in cycle t+1 when cnt was 0.
- Throughput: one beat per cycle while cnt > 0.
- Sustained full rate needs round-trip credit latency ≤ CREDIT_NUM cycles.
- Reset mid-operation discards in-flight state and credits. The receiver must be reset in the same cycle; the block relies on the receiver's post-reset credit pulses to rebuild cnt.
- m_credit_i is ignored while rst_n = 0.

## Structure
- Shared package vc_link_pkg holds:
  - function credit_cnt_width(n) returning $clog2(n+1)
  - default CREDIT_NUM/DATA_WIDTH localparams, shared with the receiver so both sides agree on depth
- One sub-module: credit_counter.
  - Parameters: MAX, W.
  - Ports: inc, dec, cnt, nonzero, overflow_err.
  - Holds the saturate/sticky-error logic and is reusable by other credit senders.
- The top level holds only the output register and the handshake decode.

## Test plan
1. Reset/initial credits: release rst_n with no credits.
   - s_ready_o = 0, m_valid_o = 0, credit_cnt_o = 0.
   - Pulse m_credit_i twice: credit_cnt_o = 1 then 2; s_ready_o = 1 from the cycle after the first pulse.
2. Credit exhaustion: cnt = 2, s_valid_i held with 0xA1, 0xA2, 0xA3.
   - m_valid_o pulses in two consecutive cycles with 0xA1, 0xA2.
   - s_ready_o drops and 0xA3 stalls.
   - One credit pulse: 0xA3 is sent 2 cycles after the pulse.
3. Simultaneous credit and send at cnt = 1: credit_cnt_o stays 1 and s_ready_o stays 1 across back-to-back beats 0x10…0x1F.
4. Overflow: cnt = 2, idle upstream, extra credit pulse.
   - credit_err_o = 1 and credit_cnt_o = 2.
   - Flag holds through further traffic; cleared only by rst_n.
5. End-to-end with the receiving converter (CREDIT_NUM = 2 and 4), random s_valid_i and random downstream m_ready_i, 10k beats.
   - Scoreboard: output equals input in order.
   - credit_err_o = 0 and credit_cnt_o ≤ CREDIT_NUM throughout.
6. Reset mid-burst: assert rst_n low for 1 cycle during a full-rate burst.
   - All outputs and credit_cnt_o are 0 on the next cycle.
   - Traffic resumes correctly after the receiver re-issues CREDIT_NUM credits.
